// File: rtl/single_cycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : single_cycle_cpu
// Purpose  : Single-cycle 32-bit MIPS-subset core (PC, ROM, regfile, ALU, RAM).
// Revision : 1.0 - initial release
// ============================================================================
module single_cycle_cpu #(
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "program.hex"
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] immediate,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] WriteData,
  output logic [31:0] DataOut,
  output logic [31:0] currentAddress,
  output logic [31:0] result
);

  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5
  } alu_op_e;

  logic [31:0] rom     [IMEM_DEPTH];
  logic [31:0] dmem_q  [DMEM_DEPTH];
  logic [31:0] rf_q    [32];
  logic [31:0] rf_d    [32];
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;

  logic [31:0] ins;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] imm_sext, imm_zext, imm_ext;
  logic [31:0] pc_plus4, branch_target, jump_target;
  logic [31:0] alu_a, alu_b;
  logic        imem_in_range, dmem_in_range;

  alu_op_e     alu_op;
  logic [4:0]  dest;
  logic        use_imm, use_zext, rf_we, mem_read, mem_write;
  logic        is_beq, is_bne, is_jump, is_halt;
  logic        rf_wr_en, dmem_wr_en, take_branch;

  // Fetch: PCs beyond the ROM see an all-zero word, which decodes as a NOP.
  assign imem_in_range  = (pc_q[31:2] < 30'(IMEM_DEPTH));
  assign ins            = imem_in_range ? rom[pc_q[IA_W+1:2]] : 32'h0;
  assign currentAddress = pc_q;

  assign op        = ins[31:26];
  assign rs        = ins[25:21];
  assign rt        = ins[20:16];
  assign rd        = ins[15:11];
  assign shamt     = ins[10:6];
  assign funct     = ins[5:0];
  assign immediate = ins[15:0];

  assign imm_sext = {{16{immediate[15]}}, immediate};
  assign imm_zext = {16'h0000, immediate};
  assign imm_ext  = use_zext ? imm_zext : imm_sext;

  always_comb begin
    alu_op    = ALU_ADD;
    dest      = rd;
    use_imm   = 1'b0;
    use_zext  = 1'b0;
    rf_we     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jump   = 1'b0;
    is_halt   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   begin alu_op = ALU_ADD; rf_we = 1'b1; end
          F_SUB:   begin alu_op = ALU_SUB; rf_we = 1'b1; end
          F_AND:   begin alu_op = ALU_AND; rf_we = 1'b1; end
          F_OR:    begin alu_op = ALU_OR;  rf_we = 1'b1; end
          F_SLT:   begin alu_op = ALU_SLT; rf_we = 1'b1; end
          F_SLL:   begin alu_op = ALU_SLL; rf_we = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDIU: begin use_imm = 1'b1; rf_we = 1'b1; dest = rt; end
      OP_SLTI:  begin use_imm = 1'b1; rf_we = 1'b1; dest = rt; alu_op = ALU_SLT; end
      OP_ANDI:  begin use_imm = 1'b1; rf_we = 1'b1; dest = rt; alu_op = ALU_AND; use_zext = 1'b1; end
      OP_ORI:   begin use_imm = 1'b1; rf_we = 1'b1; dest = rt; alu_op = ALU_OR;  use_zext = 1'b1; end
      OP_LW:    begin use_imm = 1'b1; rf_we = 1'b1; dest = rt; mem_read = 1'b1; end
      OP_SW:    begin use_imm = 1'b1; mem_write = 1'b1; end
      OP_BEQ:   is_beq  = 1'b1;
      OP_BNE:   is_bne  = 1'b1;
      OP_J:     is_jump = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      default:  ;
    endcase
  end

  // Register reads; $0 is forced to zero regardless of storage.
  assign ReadData1 = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign ReadData2 = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  assign alu_a = (alu_op == ALU_SLL) ? {27'h0, shamt} : ReadData1;
  assign alu_b = use_imm ? imm_ext : ReadData2;

  always_comb begin
    result = 32'h0;
    case (alu_op)
      ALU_ADD: result = alu_a + alu_b;
      ALU_SUB: result = alu_a - alu_b;
      ALU_AND: result = alu_a & alu_b;
      ALU_OR:  result = alu_a | alu_b;
      ALU_SLT: result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLL: result = alu_b << alu_a[4:0];
      default: result = 32'h0;
    endcase
  end

  assign dmem_in_range = (result[31:2] < 30'(DMEM_DEPTH));
  assign DataOut       = dmem_in_range ? dmem_q[result[DA_W+1:2]] : 32'h0;
  assign WriteData     = mem_read ? DataOut : result;

  assign rf_wr_en   = rf_we & ~halted_q & (dest != 5'd0);
  assign dmem_wr_en = mem_write & ~halted_q & dmem_in_range;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], ins[25:0], 2'b00};
  assign take_branch   = (is_beq & (ReadData1 == ReadData2)) |
                         (is_bne & (ReadData1 != ReadData2));

  // A halt freezes the PC on itself; the sticky flag blocks all later writes.
  always_comb begin
    halted_d = halted_q | is_halt;
    if (halted_q || is_halt) pc_d = pc_q;
    else if (is_jump)        pc_d = jump_target;
    else if (take_branch)    pc_d = branch_target;
    else                     pc_d = pc_plus4;
  end

  always_comb begin
    rf_d = rf_q;
    if (rf_wr_en) rf_d[dest] = WriteData;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q     <= 32'h0;
      halted_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      rf_q     <= rf_d;
    end
  end

  // Data RAM keeps its contents across reset.
  always_ff @(posedge CLK) begin
    if (dmem_wr_en) dmem_q[result[DA_W+1:2]] <= ReadData2;
  end

endmodule
`default_nettype wire

// File: tb/tb_single_cycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_single_cycle_cpu
// Purpose  : Directed self-checking bench for single_cycle_cpu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_single_cycle_cpu;

  logic        CLK;
  logic        Reset;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] immediate;
  logic [31:0] ReadData1, ReadData2, WriteData, DataOut, currentAddress, result;

  int n_cmp = 0;
  int n_bad = 0;

  single_cycle_cpu #(
    .IMEM_DEPTH(64),
    .DMEM_DEPTH(64),
    .IMEM_FILE ("")
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .op            (op),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .immediate     (immediate),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteData     (WriteData),
    .DataOut       (DataOut),
    .currentAddress(currentAddress),
    .result        (result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] prog [26] = '{
    32'h24010008, // 00 addiu $1,$0,8
    32'h34020002, // 04 ori   $2,$0,2
    32'h00411820, // 08 add   $3,$2,$1
    32'h00622822, // 0C sub   $5,$3,$2
    32'hAC230004, // 10 sw    $3,4($1)
    32'h8C270004, // 14 lw    $7,4($1)
    32'h24000005, // 18 addiu $0,$0,5
    32'h00023080, // 1C sll   $6,$2,2
    32'h10420002, // 20 beq   $2,$2,+2
    32'h24090001, // 24 addiu $9,$0,1 (skipped)
    32'h24090001, // 28 addiu $9,$0,1 (skipped)
    32'h14420005, // 2C bne   $2,$2,+5 (not taken)
    32'h08000010, // 30 j     0x40
    32'h24090001, // 34 (skipped)
    32'h24090001, // 38 (skipped)
    32'h24090001, // 3C (skipped)
    32'h2401FFFE, // 40 addiu $1,$0,-2
    32'h28240000, // 44 slti  $4,$1,0
    32'h00654024, // 48 and   $8,$3,$5
    32'h00655025, // 4C or    $10,$3,$5
    32'h0022582A, // 50 slt   $11,$1,$2
    32'h302CFFF0, // 54 andi  $12,$1,0xFFF0
    32'h3C0D1234, // 58 unlisted opcode -> NOP
    32'hAC030100, // 5C sw    $3,0x100($0) (out of range)
    32'h8C0E0100, // 60 lw    $14,0x100($0) (out of range)
    32'hFC000000  // 64 halt
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    Reset = 1'b0;
    for (int i = 0; i < 64; i++) dut.rom[i] = (i < 26) ? prog[i] : 32'h0;

    // Reset held across clock edges
    repeat (2) @(posedge CLK);
    step();
    chk("rst_pc",  currentAddress, 32'h0);
    chk("rst_rd1", ReadData1, 32'h0);
    chk("rst_rd2", ReadData2, 32'h0);
    chk("rst_op",  {26'h0, op}, 32'h9);
    Reset = 1'b1;

    chk("pc00",      currentAddress, 32'h00);
    chk("addiu_res", result, 32'h8);
    chk("addiu_wd",  WriteData, 32'h8);
    step();
    chk("pc04",      currentAddress, 32'h04);
    chk("ori_res",   result, 32'h2);
    step();
    chk("pc08",      currentAddress, 32'h08);
    chk("add_rd1",   ReadData1, 32'd2);
    chk("add_rd2",   ReadData2, 32'd8);
    chk("add_res",   result, 32'd10);
    chk("add_wd",    WriteData, 32'd10);
    step();
    chk("sub_res",   result, 32'd8);
    step();
    chk("sw_addr",   result, 32'd12);
    chk("sw_data",   ReadData2, 32'd10);
    step();
    chk("lw_addr",   result, 32'd12);
    chk("lw_dout",   DataOut, 32'd10);
    chk("lw_wd",     WriteData, 32'd10);
    step();
    chk("r5",        dut.rf_q[5], 32'd8);
    chk("r7",        dut.rf_q[7], 32'd10);
    chk("w0_res",    result, 32'd5);
    step();
    chk("sll_res",   result, 32'd8);
    step();
    chk("pc20",      currentAddress, 32'h20);
    chk("r0_kept",   dut.rf_q[0], 32'h0);
    step();
    chk("beq_taken", currentAddress, 32'h2C);
    chk("r6",        dut.rf_q[6], 32'd8);
    step();
    chk("bne_fall",  currentAddress, 32'h30);
    step();
    chk("j_target",  currentAddress, 32'h40);
    chk("r0_read",   ReadData1, 32'h0);
    chk("neg_res",   result, 32'hFFFF_FFFE);
    step();
    chk("slti_rd1",  ReadData1, 32'hFFFF_FFFE);
    chk("slti_res",  result, 32'd1);
    step();
    chk("and_res",   result, 32'd8);
    step();
    chk("or_res",    result, 32'd10);
    step();
    chk("slt_res",   result, 32'd1);
    step();
    chk("andi_res",  result, 32'h0000_FFF0);
    step();
    chk("pc58",      currentAddress, 32'h58);
    step();
    chk("oor_sw_a",  result, 32'h100);
    chk("oor_dout",  DataOut, 32'h0);
    step();
    chk("oor_lw_wd", WriteData, 32'h0);
    step();
    chk("halt_pc",   currentAddress, 32'h64);
    chk("r9_skip",   dut.rf_q[9], 32'h0);
    chk("r13_nop",   dut.rf_q[13], 32'h0);
    chk("r4",        dut.rf_q[4], 32'd1);
    chk("r1",        dut.rf_q[1], 32'hFFFF_FFFE);

    repeat (5) step();
    chk("halt_hold", currentAddress, 32'h64);
    chk("halt_r14",  dut.rf_q[14], 32'h0);

    // Asynchronous reset between edges
    #2 Reset = 1'b0;
    #1;
    chk("async_pc",  currentAddress, 32'h0);
    chk("async_rd2", ReadData2, 32'h0);
    chk("async_r3",  dut.rf_q[3], 32'h0);
    step();
    Reset = 1'b1;
    step();
    chk("restart",   currentAddress, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
